// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: iterative CORDIC core (rotation / vectoring), one micro-rotation per clock.
// Gain K~1.6468 is left uncompensated; callers pre-scale their operands.
module cordic_iter_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 14,
  parameter int unsigned GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o,
  output logic                    ovf_o
);

  localparam int unsigned XW      = WIDTH + GUARD;
  localparam int unsigned CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned ATAN_SH = 32 - WIDTH;
  localparam int unsigned RND_SH  = (WIDTH < 32) ? 31 - WIDTH : 0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // arctan(2^-i) with 2^31 == pi
  function automatic logic [31:0] atan32(input logic [4:0] i);
    case (i)
      5'd0:    return 32'h2000_0000;
      5'd1:    return 32'h12E4_051E;
      5'd2:    return 32'h09FB_385B;
      5'd3:    return 32'h0511_11D4;
      5'd4:    return 32'h028B_0D43;
      5'd5:    return 32'h0145_D7E1;
      5'd6:    return 32'h00A2_F61E;
      5'd7:    return 32'h0051_7C55;
      5'd8:    return 32'h0028_BE53;
      5'd9:    return 32'h0014_5F2F;
      5'd10:   return 32'h000A_2F98;
      5'd11:   return 32'h0005_17CC;
      5'd12:   return 32'h0002_8BE6;
      5'd13:   return 32'h0001_45F3;
      5'd14:   return 32'h0000_A2FA;
      5'd15:   return 32'h0000_517D;
      5'd16:   return 32'h0000_28BE;
      5'd17:   return 32'h0000_145F;
      5'd18:   return 32'h0000_0A30;
      5'd19:   return 32'h0000_0518;
      5'd20:   return 32'h0000_028C;
      5'd21:   return 32'h0000_0146;
      5'd22:   return 32'h0000_00A3;
      5'd23:   return 32'h0000_0051;
      5'd24:   return 32'h0000_0029;
      5'd25:   return 32'h0000_0014;
      5'd26:   return 32'h0000_000A;
      5'd27:   return 32'h0000_0005;
      5'd28:   return 32'h0000_0003;
      5'd29:   return 32'h0000_0001;
      5'd30:   return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Table entry scaled to WIDTH bits, rounded half-up
  function automatic logic [WIDTH-1:0] atan_w(input logic [4:0] i);
    logic [32:0] t;
    t = {1'b0, atan32(i)};
    if (WIDTH < 32) t = t + (33'(1) << RND_SH);
    return WIDTH'(t >> ATAN_SH);
  endfunction

  // Clamp a guarded value to WIDTH bits; MSB of the result flags saturation
  function automatic logic [WIDTH:0] sat(input logic signed [XW-1:0] v);
    logic [GUARD:0] top;
    top = v[XW-1:WIDTH-1];
    if ((&top) || !(|top)) return {1'b0, v[WIDTH-1:0]};
    else if (v[XW-1])      return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else                   return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    mode_q;
  logic signed [XW-1:0]    xr, yr, x_sh, y_sh, x_nx, y_nx;
  logic signed [WIDTH-1:0] zr, z_nx, atan;
  logic                    d_pos, load, step, finish;
  logic [WIDTH:0]          x_sat, y_sat;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath control decoded from state
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: load = start_i;
      RUN: begin
        step   = 1'b1;
        finish = (cnt == LAST);
      end
      default: ;
    endcase
  end

  // One micro-rotation; all three updates use the current-cycle x/y/z
  always_comb begin
    d_pos = mode_q ? yr[XW-1] : ~zr[WIDTH-1];
    atan  = atan_w(5'(cnt));
    x_sh  = xr >>> cnt;
    y_sh  = yr >>> cnt;
    x_nx  = d_pos ? xr - y_sh : xr + y_sh;
    y_nx  = d_pos ? yr + x_sh : yr - x_sh;
    z_nx  = d_pos ? zr - atan : zr + atan;
    x_sat = sat(x_nx);
    y_sat = sat(y_nx);
  end

  // Operand/iteration registers, handshake flags and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      x_o    <= '0;
      y_o    <= '0;
      z_o    <= '0;
      ovf_o  <= 1'b0;
    end else begin
      busy_o <= (state_next == RUN);
      done_o <= (state_next == DONE);
      if (load) begin
        xr     <= XW'(x_i);
        yr     <= XW'(y_i);
        zr     <= z_i;
        mode_q <= mode_i;
        cnt    <= '0;
      end else if (step) begin
        xr  <= x_nx;
        yr  <= y_nx;
        zr  <= z_nx;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        x_o   <= x_sat[WIDTH-1:0];
        y_o   <= y_sat[WIDTH-1:0];
        z_o   <= z_nx;
        ovf_o <= x_sat[WIDTH] | y_sat[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: scenario and randomized checks of cordic_iter_engine (WIDTH=16, ITER=14).
module tb_cordic_iter_engine;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITER  = 14;
  localparam int unsigned GUARD = 2;
  localparam real PI = 3.14159265358979;
  localparam int TOL = 4;

  logic clk, rst, start_i, mode_i, busy_o, done_o, ovf_o;
  logic signed [WIDTH-1:0] x_i, y_i, z_i, x_o, y_o, z_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [15:0] ex, ey, ez;
  logic eo;

  cordic_iter_engine #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .busy_o(busy_o), .done_o(done_o),
    .x_o(x_o), .y_o(y_o), .z_o(z_o), .ovf_o(ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int wrap16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Reference CORDIC: ideal arctan rounded to the angle format, unbounded x/y, clamp at the end
  function automatic void model(input logic md, input int xi, input int yi, input int zi,
                                output logic signed [15:0] xo, output logic signed [15:0] yo,
                                output logic signed [15:0] zo, output logic ov);
    longint x, y, xn, yn;
    int z, a;
    logic dp;
    real p;
    x = xi; y = yi; z = zi; ov = 1'b0; p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      a  = $rtoi($floor($atan(p) * 32768.0 / PI + 0.5));
      dp = md ? (y < 0) : (z >= 0);
      xn = dp ? x - (y >>> i) : x + (y >>> i);
      yn = dp ? y + (x >>> i) : y - (x >>> i);
      z  = wrap16(dp ? longint'(z - a) : longint'(z + a));
      x  = xn;
      y  = yn;
      p  = p / 2.0;
    end
    if (x > 32767) begin x = 32767; ov = 1'b1; end
    else if (x < -32768) begin x = -32768; ov = 1'b1; end
    if (y > 32767) begin y = 32767; ov = 1'b1; end
    else if (y < -32768) begin y = -32768; ov = 1'b1; end
    xo = 16'(x);
    yo = 16'(y);
    zo = 16'(z);
  endfunction

  // Launch one operation and return the cycle of done_o (-1 if it never came)
  task automatic run_op(input logic md, input int xa, input int ya, input int za, output int lat);
    @(negedge clk);
    mode_i = md; x_i = 16'(xa); y_i = 16'(ya); z_i = 16'(za); start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 3 * ITER; c++) begin
      if (done_o === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    start_i = 1'b0; mode_i = 1'b0; x_i = '0; y_i = '0; z_i = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b, want 0 0", busy_o, done_o);
    end
    n_tests++;
    if ({x_o, y_o, z_o, ovf_o} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%0d y=%0d z=%0d ovf=%b, want all 0", x_o, y_o, z_o, ovf_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_rotation;
    int lat;
    int xs [2] = '{9949, 9949};
    int zs [2] = '{0, 8192};
    int xn [2] = '{16384, 11585};
    int yn [2] = '{0, 11585};
    for (int k = 0; k < 2; k++) begin
      run_op(1'b0, xs[k], 0, zs[k], lat);
      n_tests++;
      if (lat !== 15) begin
        n_fail++;
        $display("FAIL rot%0d_latency: done at cycle %0d, want 15", k, lat);
      end
      model(1'b0, xs[k], 0, zs[k], ex, ey, ez, eo);
      n_tests++;
      if ({x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
        n_fail++;
        $display("FAIL rot%0d_model: got %0d %0d %0d ovf=%b, want %0d %0d %0d ovf=%b",
                 k, x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
      end
      n_tests++;
      if (iabs(int'(x_o) - xn[k]) > TOL || iabs(int'(y_o) - yn[k]) > TOL ||
          iabs(int'(z_o)) > TOL || ovf_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rot%0d_nominal: got %0d %0d %0d ovf=%b, want ~%0d ~%0d ~0 ovf=0",
                 k, x_o, y_o, z_o, ovf_o, xn[k], yn[k]);
      end
    end
  endtask

  task automatic test_vectoring;
    int lat;
    int ys [2] = '{10000, -10000};
    int zn [2] = '{8192, -8192};
    for (int k = 0; k < 2; k++) begin
      run_op(1'b1, 10000, ys[k], 0, lat);
      n_tests++;
      if (lat !== 15) begin
        n_fail++;
        $display("FAIL vec%0d_latency: done at cycle %0d, want 15", k, lat);
      end
      model(1'b1, 10000, ys[k], 0, ex, ey, ez, eo);
      n_tests++;
      if ({x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
        n_fail++;
        $display("FAIL vec%0d_model: got %0d %0d %0d ovf=%b, want %0d %0d %0d ovf=%b",
                 k, x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
      end
      n_tests++;
      if (iabs(int'(x_o) - 23290) > TOL || iabs(int'(y_o)) > TOL ||
          iabs(int'(z_o) - zn[k]) > TOL) begin
        n_fail++;
        $display("FAIL vec%0d_nominal: got %0d %0d %0d, want ~23290 ~0 ~%0d",
                 k, x_o, y_o, z_o, zn[k]);
      end
    end
  endtask

  task automatic test_handshake;
    logic signed [15:0] px, py, pz;
    logic po, exp_busy, exp_done;
    int k;
    @(negedge clk);
    px = x_o; py = y_o; pz = z_o; po = ovf_o;
    mode_i = 1'b0; x_i = 16'sd9949; y_i = '0; z_i = '0;
    model(1'b0, 9949, 0, 0, ex, ey, ez, eo);
    for (int c = 0; c <= 32; c++) begin
      start_i = (c == 0 || c == 3 || c == 15 || c == 16);
      @(posedge clk);
      @(negedge clk);
      k = c + 1;
      exp_busy = (k >= 1 && k <= 14) || (k >= 17 && k <= 30);
      exp_done = (k == 15 || k == 31);
      n_tests++;
      if (busy_o !== exp_busy || done_o !== exp_done) begin
        n_fail++;
        $display("FAIL hs_cycle%0d: busy=%b done=%b, want busy=%b done=%b",
                 k, busy_o, done_o, exp_busy, exp_done);
      end
      if (k == 8) begin
        n_tests++;
        if ({x_o, y_o, z_o, ovf_o} !== {px, py, pz, po}) begin
          n_fail++;
          $display("FAIL hs_hold: got %0d %0d %0d ovf=%b, want %0d %0d %0d ovf=%b",
                   x_o, y_o, z_o, ovf_o, px, py, pz, po);
        end
      end
      if (k == 31) begin
        n_tests++;
        if ({x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
          n_fail++;
          $display("FAIL hs_result: got %0d %0d %0d ovf=%b, want %0d %0d %0d ovf=%b",
                   x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
        end
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int lat, dones;
    @(negedge clk);
    mode_i = 1'b0; x_i = 16'sd9949; y_i = '0; z_i = '0; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags: busy=%b done=%b, want 0 0", busy_o, done_o);
    end
    n_tests++;
    if ({x_o, y_o, z_o, ovf_o} !== 49'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: x=%0d y=%0d z=%0d ovf=%b, want all 0", x_o, y_o, z_o, ovf_o);
    end
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b1;
      if (done_o === 1'b1) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: %0d done pulses, want 0", dones);
    end
    run_op(1'b0, 9949, 0, 0, lat);
    model(1'b0, 9949, 0, 0, ex, ey, ez, eo);
    n_tests++;
    if (lat !== 15 || {x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
      n_fail++;
      $display("FAIL midrst_restart: lat=%0d got %0d %0d %0d ovf=%b, want lat=15 %0d %0d %0d ovf=%b",
               lat, x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
    end
  endtask

  task automatic test_saturation;
    int lat;
    run_op(1'b1, 32767, 32767, 0, lat);
    n_tests++;
    if (lat !== 15 || x_o !== 16'sd32767 || ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clamp: lat=%0d x=%0d ovf=%b, want lat=15 x=32767 ovf=1", lat, x_o, ovf_o);
    end
    model(1'b1, 32767, 32767, 0, ex, ey, ez, eo);
    n_tests++;
    if ({x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
      n_fail++;
      $display("FAIL sat_model: got %0d %0d %0d ovf=%b, want %0d %0d %0d ovf=%b",
               x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
    end
    run_op(1'b0, 9949, 0, 0, lat);
    n_tests++;
    if (ovf_o !== 1'b0 || iabs(int'(x_o) - 16384) > TOL) begin
      n_fail++;
      $display("FAIL sat_cleared: x=%0d ovf=%b, want ~16384 ovf=0", x_o, ovf_o);
    end
  endtask

  task automatic test_back_to_back;
    int ndone;
    logic exp_done;
    model(1'b0, 9949, 0, 8192, ex, ey, ez, eo);
    @(negedge clk);
    mode_i = 1'b0; x_i = 16'sd9949; y_i = '0; z_i = 16'sd8192; start_i = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      exp_done = ((c % 16) == 15);
      n_tests++;
      if (done_o !== exp_done) begin
        n_fail++;
        $display("FAIL b2b_done_c%0d: done=%b, want %b", c, done_o, exp_done);
      end
      if (done_o === 1'b1) begin
        ndone++;
        n_tests++;
        if ({x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %0d %0d %0d ovf=%b, want %0d %0d %0d ovf=%b",
                   ndone, x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
        end
      end
    end
    start_i = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_random;
    int lat, xa, ya, za;
    logic md;
    for (int n = 0; n < 24; n++) begin
      md = 1'($urandom_range(0, 1));
      ya = int'($urandom_range(0, 65535)) - 32768;
      if (md) begin
        xa = int'($urandom_range(0, 32767));
        za = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        xa = int'($urandom_range(0, 65535)) - 32768;
        za = int'($urandom_range(0, 32768)) - 16384;
      end
      run_op(md, xa, ya, za, lat);
      model(md, xa, ya, za, ex, ey, ez, eo);
      n_tests++;
      if (lat !== 15 || {x_o, y_o, z_o, ovf_o} !== {ex, ey, ez, eo}) begin
        n_fail++;
        $display("FAIL rand%0d m=%b in=%0d,%0d,%0d: lat=%0d got %0d %0d %0d ovf=%b, want lat=15 %0d %0d %0d ovf=%b",
                 n, md, xa, ya, za, lat, x_o, y_o, z_o, ovf_o, ex, ey, ez, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_handshake();
    test_reset_midrun();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
